// File: rtl/dmem_pkg.sv
// Shared data-memory access definitions: size encodings, response FSM states
// and the alignment check reused by the load/store unit.
package dmem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } resp_state_t;

  // Size 2'b11 is not a legal encoding and is reported like a misalignment.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_WORD: bad = (addr_lo != 2'b00);
      SZ_HALF: bad = addr_lo[0];
      SZ_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. On a tie the port not granted most recently
// wins; the pointer only moves when a grant is actually issued.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic r_last;
  logic [1:0] w_gnt;

  always_comb begin
    w_gnt = 2'b00;
    if (!reset) begin
      if (req == 2'b11) begin
        w_gnt = r_last ? 2'b01 : 2'b10;
      end else begin
        w_gnt = req;
      end
    end
  end

  assign gnt = w_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (|w_gnt) begin
      r_last <= w_gnt[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU (port 0) and the
// debug/DMA loader (port 1), with alignment checking and a 1-cycle response.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  logic [1:0]  w_gnt;
  logic        w_any;
  logic        w_sel;
  logic        w_we;
  logic [1:0]  w_size;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_err;
  logic [1:0]  w_rvalid;

  resp_state_t r_state, w_state_next;
  logic        r_port;
  logic        r_err;
  logic [31:0] r_rdata;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({m1_req, m0_req}),
    .gnt   (w_gnt)
  );

  assign w_any = |w_gnt;
  assign w_sel = w_gnt[1];

  always_comb begin
    w_we    = w_sel ? m1_we    : m0_we;
    w_size  = w_sel ? m1_size  : m0_size;
    w_addr  = w_sel ? m1_addr  : m0_addr;
    w_wdata = w_sel ? m1_wdata : m0_wdata;
    w_err   = w_any & misaligned(w_size, w_addr[1:0]);
  end

  // Only the low ADDR_W bits matter to the memory; the rest are forwarded as-is.
  assign mem_we    = w_any & w_we & ~w_err;
  assign mem_size  = w_any ? w_size : 2'b00;
  assign mem_addr  = w_any ? {w_addr[31:ADDR_W], w_addr[ADDR_W-1:0]} : 32'h0;
  assign mem_wdata = w_any ? w_wdata : 32'h0;

  assign m0_gnt = w_gnt[0];
  assign m1_gnt = w_gnt[1];

  always_comb begin
    w_state_next = ST_IDLE;
    if (w_any) begin
      w_state_next = ST_RESP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_port  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      r_state <= w_state_next;
      if (w_any) begin
        r_port  <= w_sel;
        r_err   <= w_err;
        // Stores and rejected accesses return zero data.
        r_rdata <= (w_we | w_err) ? 32'h0 : mem_rdata;
      end
    end
  end

  // A pending response is dropped as soon as reset is seen.
  assign w_rvalid[0] = ~reset & (r_state == ST_RESP) & ~r_port;
  assign w_rvalid[1] = ~reset & (r_state == ST_RESP) &  r_port;

  assign m0_rvalid = w_rvalid[0];
  assign m1_rvalid = w_rvalid[1];
  assign m0_err    = w_rvalid[0] & r_err;
  assign m1_err    = w_rvalid[1] & r_err;
  assign m0_rdata  = w_rvalid[0] ? r_rdata : 32'h0;
  assign m1_rdata  = w_rvalid[1] ? r_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-addressed memory model
// that sign-extends half/byte loads.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0] tb_mem [0:255];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(12)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: combinational read, write on the rising edge.
  always_comb begin
    logic [7:0] a;
    a = mem_addr[7:0];
    case (mem_size)
      2'b00:   mem_rdata = {tb_mem[a+8'd3], tb_mem[a+8'd2], tb_mem[a+8'd1], tb_mem[a]};
      2'b01:   mem_rdata = {{16{tb_mem[a+8'd1][7]}}, tb_mem[a+8'd1], tb_mem[a]};
      default: mem_rdata = {{24{tb_mem[a][7]}}, tb_mem[a]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_we) begin
      tb_mem[mem_addr[7:0]] <= mem_wdata[7:0];
      if (mem_size != 2'b10) tb_mem[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
      if (mem_size == 2'b00) begin
        tb_mem[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
        tb_mem[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end else begin
      $display("ok   %s = %h", tag, obs);
    end
  endtask

  task automatic set0(input logic req, input logic we, input logic [1:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata);
    m0_req = req; m0_we = we; m0_size = size; m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic set1(input logic req, input logic we, input logic [1:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata);
    m1_req = req; m1_we = we; m1_size = size; m1_addr = addr; m1_wdata = wdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input int a);
    return {tb_mem[a+3], tb_mem[a+2], tb_mem[a+1], tb_mem[a]};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'h00;
    {tb_mem[8'h23], tb_mem[8'h22], tb_mem[8'h21], tb_mem[8'h20]} = 32'h11223344;

    reset = 1'b1;
    set0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    set1(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_gnt0", {31'd0, m0_gnt}, 32'd0);
    chk("rst_rvalid0", {31'd0, m0_rvalid}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_rdata0", m0_rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Port 0 word store then word load
    set0(1'b1, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    chk("st_gnt0", {31'd0, m0_gnt}, 32'd1);
    chk("st_gnt1", {31'd0, m1_gnt}, 32'd0);
    chk("st_mem_we", {31'd0, mem_we}, 32'd1);
    chk("st_mem_addr", mem_addr, 32'h10);
    chk("st_rvalid0", {31'd0, m0_rvalid}, 32'd0);
    next_cycle();
    set0(1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
    @(negedge clk);
    chk("ld_gnt0", {31'd0, m0_gnt}, 32'd1);
    chk("ld_mem_we", {31'd0, mem_we}, 32'd0);
    chk("st_resp_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("st_resp_err", {31'd0, m0_err}, 32'd0);
    chk("st_resp_rdata", m0_rdata, 32'h0);
    next_cycle();
    set0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    chk("ld_resp_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("ld_resp_rdata", m0_rdata, 32'hDEADBEEF);
    chk("ld_resp_err", {31'd0, m0_err}, 32'd0);
    chk("ld_resp_rvalid1", {31'd0, m1_rvalid}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("idle_rvalid0", {31'd0, m0_rvalid}, 32'd0);

    // Port 1 alone, leaves the pointer on port 1
    next_cycle();
    set1(1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
    @(negedge clk);
    chk("p1_gnt1", {31'd0, m1_gnt}, 32'd1);
    next_cycle();
    set1(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    chk("p1_rvalid1", {31'd0, m1_rvalid}, 32'd1);
    chk("p1_rdata1", m1_rdata, 32'hDEADBEEF);
    next_cycle();

    // Continuous tie for 6 cycles: grants 0,1,0,1,0,1
    for (int k = 0; k <= 6; k++) begin
      if (k < 6) begin
        set0(1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
        set1(1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
      end else begin
        set0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        set1(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      end
      @(negedge clk);
      chk($sformatf("tie%0d_gnt0", k), {31'd0, m0_gnt}, (k < 6 && k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("tie%0d_gnt1", k), {31'd0, m1_gnt}, (k < 6 && k % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("tie%0d_rv0", k), {31'd0, m0_rvalid}, (k > 0 && k % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("tie%0d_rv1", k), {31'd0, m1_rvalid}, (k > 0 && k % 2 == 0) ? 32'd1 : 32'd0);
      if (k > 0) chk($sformatf("tie%0d_rdata", k), (k % 2 == 1) ? m0_rdata : m1_rdata, 32'hDEADBEEF);
      next_cycle();
    end

    // Misaligned half store, then misaligned word load
    set0(1'b1, 1'b1, 2'b01, 32'h21, 32'h0000ABCD);
    @(negedge clk);
    chk("mis_st_gnt0", {31'd0, m0_gnt}, 32'd1);
    chk("mis_st_mem_we", {31'd0, mem_we}, 32'd0);
    next_cycle();
    set0(1'b1, 1'b0, 2'b00, 32'h22, 32'h0);
    @(negedge clk);
    chk("mis_ld_mem_we", {31'd0, mem_we}, 32'd0);
    chk("mis_st_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("mis_st_err", {31'd0, m0_err}, 32'd1);
    chk("mis_st_rdata", m0_rdata, 32'h0);
    next_cycle();
    set0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    chk("mis_ld_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("mis_ld_err", {31'd0, m0_err}, 32'd1);
    chk("mis_ld_rdata", m0_rdata, 32'h0);
    chk("mis_mem20", mem_word(32'h20), 32'h11223344);
    next_cycle();

    // Byte store on port 0, byte load of the same byte on port 1 next cycle
    set0(1'b1, 1'b1, 2'b10, 32'h33, 32'h00000080);
    @(negedge clk);
    chk("b_st_mem_we", {31'd0, mem_we}, 32'd1);
    chk("b_st_mem_size", {30'd0, mem_size}, 32'd2);
    chk("b_st_mem_wdata", mem_wdata, 32'h80);
    next_cycle();
    set0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    set1(1'b1, 1'b0, 2'b10, 32'h33, 32'h0);
    @(negedge clk);
    chk("b_ld_gnt1", {31'd0, m1_gnt}, 32'd1);
    chk("b_st_rvalid0", {31'd0, m0_rvalid}, 32'd1);
    next_cycle();
    set1(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    chk("b_ld_rvalid1", {31'd0, m1_rvalid}, 32'd1);
    chk("b_ld_rdata1", m1_rdata, 32'hFFFFFF80);
    chk("b_ld_err1", {31'd0, m1_err}, 32'd0);
    next_cycle();

    // Reset during a store, with a response pending from the cycle before
    set1(1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
    next_cycle();
    set1(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    set0(1'b1, 1'b1, 2'b00, 32'h40, 32'hCAFEF00D);
    reset = 1'b1;
    @(negedge clk);
    chk("rs_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rs_rvalid1", {31'd0, m1_rvalid}, 32'd0);
    next_cycle();
    reset = 1'b0;
    set0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    chk("rs_mem40", mem_word(32'h40), 32'h0);
    chk("rs_after_rv0", {31'd0, m0_rvalid}, 32'd0);
    chk("rs_after_rv1", {31'd0, m1_rvalid}, 32'd0);
    chk("rs_after_rdata", m0_rdata | m1_rdata, 32'h0);
    chk("rs_after_mem_addr", mem_addr, 32'h0);
    chk("rs_after_we", {31'd0, mem_we}, 32'd0);
    next_cycle();
    set0(1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
    set1(1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
    @(negedge clk);
    chk("rs_tie_gnt0", {31'd0, m0_gnt}, 32'd1);
    chk("rs_tie_gnt1", {31'd0, m1_gnt}, 32'd0);
    next_cycle();
    set0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    set1(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between two requesters: port 0 (CPU load/store unit) and port 1 (debug/DMA loader). Grants one access per cycle using round-robin priority and drives the memory's write-enable, size, address and write-data lines. It also rejects misaligned or invalid-size accesses, and returns registered read data with a one-cycle response handshake.

## Interface
Parameters:
- ADDR_W, 12, byte-address bits checked and forwarded; upper address bits pass through unchanged.

Ports:
- Clock and reset (one clock; reset is synchronous and active-high):
  - clk  in  1  system clock; all state updates on rising edge.
  - reset  in  1  synchronous, active-high reset.
- Per requester, n = 0, 1:
  - mn_req  in  1  access request; held with fields stable until granted.
  - mn_we  in  1  1 = store, 0 = load.
  - mn_size  in  2  00 word, 01 half, 10 byte, 11 invalid.
  - mn_addr  in  32  byte address.
  - mn_wdata  in  32  store data, right-justified for half/byte.
  - mn_gnt  out  1  combinational; request accepted this cycle.
  - mn_rvalid  out  1  response valid, one cycle after grant.
  - mn_rdata  out  32  registered load data (sign-extended by memory); 0 for stores.
  - mn_err  out  1  qualifies mn_rvalid; access was misaligned or had invalid size.
- Memory side:
  - mem_we  out  1  memory write enable.
  - mem_size  out  2  drives memory store and load size selects.
  - mem_addr  out  32  forwarded address.
  - mem_wdata  out  32  forwarded store data.
  - mem_rdata  in  32  combinational memory read data.

## Operation
- Arbitration:
  - Priority pointer `last` records the port granted most recently.
  - If only one port requests, that port is granted.
  - If both request, the port other than `last` is granted.
  - `last` updates on every grant.
  - Reset value of `last` is 1, so port 0 wins the first tie.
- Memory outputs:
  - Granted port's fields are muxed combinationally onto mem_size, mem_addr and mem_wdata.
  - With no grant, all memory outputs are 0.
- Error check:
  - Error conditions: size 11; half with addr[0]=1; word with addr[1:0]≠00.
  - Errored access: mem_we forced 0, memory untouched, response carries err=1 and rdata=0.
- Writes: mem_we = granted & mn_we & ~error. The memory commits on the same rising edge as the grant.
- Reads: mem_rdata is captured into the response register on the grant edge.
- Response FSM, one state per cycle:
  - IDLE → RESP when a grant occurs.
  - RESP → RESP on a new grant.
  - RESP → IDLE when there is no grant.
  - In RESP, rvalid is asserted only to the port granted in the previous cycle.
- Reset values: all mn_gnt, mn_rvalid, mn_err = 0; mn_rdata = 0; mem_we = 0; state IDLE.

## Timing
- Grant latency: 0 cycles. mn_gnt is high in the same cycle as mn_req when that port wins.
- Response latency: exactly 1 cycle after the grant cycle, for both loads and stores.
- Throughput: one access per cycle, back-to-back. Under continuous dual requests, grants alternate 0,1,0,1….
- Simultaneous events: a new grant and the previous access's rvalid coexist in the same cycle. The response register must not lose the earlier result.
- A requester deasserting req before gnt is legal. Nothing is issued and `last` is unchanged.
- Reset asserted mid-operation: any pending rvalid is dropped, and the in-flight cycle's write is suppressed (mem_we=0 while reset=1).
- Loads see the memory state as it was before that edge's write. No read-after-write forwarding is needed, because only one access issues per cycle.

## Structure
- Shared package `dmem_pkg`:
  - Size constants SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10.
  - Function `misaligned(size, addr[1:0])`, reused by load/store unit checks.
- Sub-module `rr_arb2`: two-input round-robin arbiter (req[1:0] in, gnt[1:0] out, internal `last` flop).
- Top level holds the mux, error check, response register and FSM.

## Test plan
- Port 0 only: word store 0xDEADBEEF to 0x10, then word load 0x10.
  - gnt same cycle each time; rvalid 1 cycle later.
  - rdata=0xDEADBEEF, err=0.
- Both ports request continuously for 6 cycles:
  - Grants follow 0,1,0,1,0,1.
  - Each rvalid goes only to the port granted the cycle before.
- Misaligned half store to 0x21, then word load 0x22:
  - mem_we stays 0.
  - Both responses have err=1, rdata=0.
  - Memory word at 0x20 is unchanged.
- Byte store 0x80 to 0x33, then byte load 0x33 on the other port in the next cycle:
  - rdata=0xFFFFFF80.
- Reset asserted in the same cycle as a granted store:
  - No write occurs.
  - The next cycle has all outputs 0 and no rvalid.
  - A following tie grants port 0.
